fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the program counter and the instruction-memory fetch handshake for the single-issue RV32 core. Issues one fetch at a time at the current PC and presents each returned instruction, with its PC, to decode over a valid/ready interface. Applies branch/jump redirects at any point and discards stale in-flight responses. Replaces the free-running PC register with a stall- and latency-tolerant sequencer.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, PC loaded on reset
INST_BYTES, 4, PC increment per sequential instruction

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  DATA_WIDTH  new PC; bits [1:0] forced to 0 internally
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  DATA_WIDTH  fetch address, sampled only on handshake
imem_rsp_valid  input  1  response valid, one cycle, 1+ cycles after accept
imem_rsp_data  input  DATA_WIDTH  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst_data  output  DATA_WIDTH  instruction word
inst_pc  output  DATA_WIDTH  PC of inst_data
pc  output  DATA_WIDTH  current fetch PC (pc_q)
fetch_count  output  DATA_WIDTH  instructions delivered (inst handshakes), wraps

Behaviour:
- Reset (rst=1 at a clock edge): pc_q=RESET_PC, state=REQ, inst_valid=0, inst_data=0, inst_pc=0, fetch_count=0. imem_req_valid=0 while rst is high. Reset in any state abandons all in-flight work. A response arriving after reset is a protocol violation (bench assertion).
- States: REQ, WAIT, HOLD, DISCARD. All outputs derive from registers or state decode; no input-to-output combinational path.
- REQ: imem_req_valid=1, imem_req_addr=pc_q.
  - Handshake without redirect: go to WAIT.
  - Handshake with redirect in the same cycle: pc_q<=target, go to DISCARD (the old-address request is in flight).
  - Redirect without handshake: pc_q<=target, stay in REQ. imem_req_addr changes to the target next cycle; this is legal because the address is sampled only on handshake.
- WAIT: imem_req_valid=0.
  - rsp_valid without redirect: inst_data<=rsp_data, inst_pc<=pc_q, pc_q<=pc_q+INST_BYTES (mod 2^DATA_WIDTH), go to HOLD.
  - rsp_valid with redirect: drop the response, pc_q<=target, go to REQ.
  - Redirect without rsp_valid: pc_q<=target, go to DISCARD.
- HOLD: inst_valid=1, with inst_data and inst_pc stable until handshake.
  - inst_ready: fetch_count+1, go to REQ.
  - Redirect, with or without inst_ready: pc_q<=target, go to REQ. If inst_ready was high in that cycle the instruction counts as delivered; if not, it is dropped. inst_valid=0 next cycle in both cases.
- DISCARD: imem_req_valid=0, inst_valid=0.
  - rsp_valid: drop the response, go to REQ.
  - Redirect: pc_q<=target, stay in DISCARD. The latest target wins.
- rsp_valid in REQ or HOLD is a protocol violation: ignore it; the bench asserts it never happens.
- Redirect always has priority over sequential increment for pc_q.
- Peak throughput: one instruction every 3 cycles at 1-cycle memory latency with inst_ready tied high.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000; no flag.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_e {REQ, WAIT, HOLD, DISCARD}
  - localparams INST_BYTES_DEF and RESET_PC_DEF
  - alignment mask constant
- No sub-module. Single module: state register, PC register, instruction holding register, counter.

Test Plan:
- Sequential fetch: reset, memory ready=1, latency 1, inst_ready=1 → inst_pc sequence 0x0, 0x4, 0x8, 0xC; fetch_count=4 after the 4th handshake; imem_req_addr matches each inst_pc.
- Backpressure: inst_ready=0 for 5 cycles in HOLD → inst_valid, inst_data and inst_pc stable; no new imem_req_valid; fetch_count unchanged until inst_ready=1.
- Redirect in WAIT: request 0x8 accepted, redirect to 0x103 before the response (latency 3) → response for 0x8 discarded, next request addr 0x100, next inst_pc 0x100.
- Redirect in the same cycle as rsp_valid: redirect to 0x40 → no inst_valid for the old word; next request addr 0x40.
- Double redirect in DISCARD: targets 0x200 then 0x300 before the stale response → next request addr 0x300.
- Reset mid-HOLD and wrap: rst asserted in HOLD → inst_valid=0, pc=RESET_PC next cycle. With RESET_PC=0xFFFF_FFFC, after the first delivery the next request addr is 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   // Sequencer states: issue a request, wait for its response, hold the
   // instruction for decode, or swallow a response that a redirect made stale.
   typedef enum logic [1:0] {
      REQ     = 2'd0,
      WAIT    = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_e;

   localparam int unsigned INST_BYTES_DEF = 4;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

   // Low address bits cleared on every redirect target (word alignment).
   localparam logic [31:0] ALIGN_LOW_MASK = 32'h0000_0003;

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response
// and the instruction handshake towards decode.
//
// Handshake rule for both *_valid/*_ready pairs: a transfer happens in a cycle
// where valid and ready are both high at the rising clock edge; once valid is
// raised the payload stays stable until that transfer, except that a redirect
// may withdraw a pending instruction or retarget a request that was not yet
// accepted (the request address is only sampled at the transfer).
// imem_rsp_valid has no ready: it is a one-cycle pulse, one or more cycles
// after the request was accepted.
interface fetch_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_target;

   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [DATA_WIDTH-1:0] imem_req_addr;
   logic                  imem_rsp_valid;
   logic [DATA_WIDTH-1:0] imem_rsp_data;

   logic                  inst_valid;
   logic                  inst_ready;
   logic [DATA_WIDTH-1:0] inst_data;
   logic [DATA_WIDTH-1:0] inst_pc;

   // Sequencer side.
   modport master (
      input  redirect_valid, redirect_target,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_ready,
      output imem_req_valid, imem_req_addr,
      output inst_valid, inst_data, inst_pc
   );

   // Environment side: memory, decode and branch unit.
   modport slave (
      output redirect_valid, redirect_target,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_ready,
      input  imem_req_valid, imem_req_addr,
      input  inst_valid, inst_data, inst_pc
   );

endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch handshake controller. One fetch in flight at a
// time; each returned word is held for decode together with its PC. Redirects
// take effect in any state and poison any response still in flight.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF),
   parameter int                    INST_BYTES = INST_BYTES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_if.master               bus,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] fetch_count,
   output fetch_state_e          dbg_state
);

   localparam logic [1:0] ST_REQ     = REQ;
   localparam logic [1:0] ST_WAIT    = WAIT;
   localparam logic [1:0] ST_HOLD    = HOLD;
   localparam logic [1:0] ST_DISCARD = DISCARD;

   logic [1:0]            state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] inst_data_q;
   logic [DATA_WIDTH-1:0] inst_pc_q;
   logic [DATA_WIDTH-1:0] count_q;

   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] pc_seq;

   assign target = bus.redirect_target & ~DATA_WIDTH'(ALIGN_LOW_MASK);
   assign pc_seq = pc_q + DATA_WIDTH'(INST_BYTES);

   // Outputs are pure state/register decode; the request is held off during reset.
   assign bus.imem_req_valid = (state_q == ST_REQ) && !rst;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = (state_q == ST_HOLD);
   assign bus.inst_data      = inst_data_q;
   assign bus.inst_pc        = inst_pc_q;
   assign pc                 = pc_q;
   assign fetch_count        = count_q;
   assign dbg_state          = fetch_state_e'(state_q);

   // Sequencer state, PC, holding register and delivery counter; a redirect
   // always overrides the sequential PC update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
         count_q     <= '0;
      end else begin
         case (state_q)
            ST_REQ: begin
               if (bus.redirect_valid) begin
                  pc_q    <= target;
                  // An accepted old-address request must still be drained.
                  state_q <= bus.imem_req_ready ? ST_DISCARD : ST_REQ;
               end else if (bus.imem_req_ready) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.redirect_valid) begin
                  pc_q <= target;
                  // A response in the redirect cycle is simply dropped.
                  state_q <= bus.imem_rsp_valid ? ST_REQ : ST_DISCARD;
               end else if (bus.imem_rsp_valid) begin
                  inst_data_q <= bus.imem_rsp_data;
                  inst_pc_q   <= pc_q;
                  pc_q        <= pc_seq;
                  state_q     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.inst_ready) begin
                  count_q <= count_q + DATA_WIDTH'(1);
               end
               if (bus.redirect_valid) begin
                  pc_q    <= target;
                  state_q <= ST_REQ;
               end else if (bus.inst_ready) begin
                  state_q <= ST_REQ;
               end
            end
            ST_DISCARD: begin
               if (bus.redirect_valid) begin
                  pc_q <= target;
               end
               if (bus.imem_rsp_valid) begin
                  state_q <= ST_REQ;
               end
            end
            default: state_q <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a latency-randomised memory, a randomly stalling
// decode stage and a random branch unit, checked against a transaction-level
// model of which instruction words must reach decode and where fetch goes next.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk;
   logic rst;
   logic redirect_valid;
   logic [31:0] redirect_target;
   logic req_ready;
   logic rsp_valid;
   logic [31:0] rsp_data;
   logic inst_ready;
   logic [31:0] pc;
   logic [31:0] fetch_count;
   fetch_state_e dbg_state;

   fetch_if #(.DATA_WIDTH(32)) bus ();

   assign bus.redirect_valid  = redirect_valid;
   assign bus.redirect_target = redirect_target;
   assign bus.imem_req_ready  = req_ready;
   assign bus.imem_rsp_valid  = rsp_valid;
   assign bus.imem_rsp_data   = rsp_data;
   assign bus.inst_ready      = inst_ready;

   fetch_sequencer #(
      .DATA_WIDTH(32),
      .RESET_PC  (RST_PC),
      .INST_BYTES(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .pc         (pc),
      .fetch_count(fetch_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus knobs (percentages and memory latency range).
   bit   do_rst = 1'b0;
   bit   force_redir = 1'b0;
   logic [31:0] force_tgt = '0;
   int   p_req = 100, p_inst = 100, p_redir = 0, lat_lo = 0, lat_hi = 0;

   // Memory model.
   bit   pend = 1'b0;
   int   lat_cnt = 0;
   logic [31:0] pend_addr = '0;

   // Reference model: where fetch must go next, whether the outstanding
   // request is still wanted, and which words decode is owed.
   logic [31:0] exp_pc = RST_PC;
   bit   live = 1'b0;
   logic [31:0] live_addr = '0;
   logic [31:0] exp_q[$];
   logic [31:0] dlv_pcs[$];
   logic [31:0] delivered = '0;
   logic [31:0] last_req_addr = '0;
   int   n_req = 0;
   bit   prev_hold = 1'b0, after_rst = 1'b0;
   logic [31:0] prev_data = '0, prev_pc = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic step();
      bit req_fire, inst_fire;
      @(negedge clk);
      rst             = do_rst;
      rsp_valid       = !do_rst && pend && (lat_cnt == 0);
      rsp_data        = rsp_valid ? mem_word(pend_addr) : $urandom;
      req_ready       = ($urandom_range(0, 99) < p_req);
      inst_ready      = ($urandom_range(0, 99) < p_inst);
      redirect_valid  = force_redir || ($urandom_range(0, 99) < p_redir);
      redirect_target = force_redir ? force_tgt : $urandom;
      force_redir     = 1'b0;
      #1;
      if (do_rst) begin
         check_eq("req_valid_in_rst", 32'(bus.imem_req_valid), 32'd0);
         exp_pc = RST_PC; live = 1'b0; pend = 1'b0;
         exp_q.delete(); dlv_pcs.delete();
         delivered = '0; prev_hold = 1'b0; after_rst = 1'b1;
      end else begin
         check_eq("pc", pc, exp_pc);
         check_eq("fetch_count", fetch_count, delivered);
         check_eq("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
         check_eq("req_valid", 32'(bus.imem_req_valid), 32'(!pend && exp_q.size() == 0));
         check_eq("hold_state", 32'(dbg_state == HOLD), 32'(exp_q.size() != 0));
         if (after_rst) begin
            check_eq("rst_inst_data", bus.inst_data, 32'd0);
            check_eq("rst_inst_pc", bus.inst_pc, 32'd0);
         end
         if (prev_hold) begin
            check_eq("hold_data_stable", bus.inst_data, prev_data);
            check_eq("hold_pc_stable", bus.inst_pc, prev_pc);
         end
         req_fire  = bus.imem_req_valid && req_ready;
         inst_fire = bus.inst_valid && inst_ready;
         if (req_fire) begin
            check_eq("req_addr", bus.imem_req_addr, exp_pc);
            last_req_addr = bus.imem_req_addr;
            n_req++;
         end
         if (inst_fire) begin
            if (exp_q.size() != 0) begin
               check_eq("inst_pc", bus.inst_pc, exp_q[0]);
               check_eq("inst_data", bus.inst_data, mem_word(exp_q[0]));
               void'(exp_q.pop_front());
            end
            delivered++;
            dlv_pcs.push_back(bus.inst_pc);
         end
         if (redirect_valid) begin
            // Held-but-not-taken instruction is withdrawn; anything in flight is stale.
            if (!inst_fire && exp_q.size() != 0) void'(exp_q.pop_front());
            live   = 1'b0;
            exp_pc = redirect_target & ~32'h3;
         end else begin
            if (rsp_valid && live) begin
               exp_q.push_back(live_addr);
               exp_pc = live_addr + 32'd4;
               live   = 1'b0;
            end
            if (req_fire) begin
               live      = 1'b1;
               live_addr = bus.imem_req_addr;
            end
         end
         if (rsp_valid) pend = 1'b0;
         else if (pend) lat_cnt--;
         if (req_fire) begin
            pend      = 1'b1;
            pend_addr = bus.imem_req_addr;
            lat_cnt   = int'($urandom_range(lat_lo, lat_hi));
         end
         prev_hold = bus.inst_valid && !inst_ready && !redirect_valid;
         prev_data = bus.inst_data;
         prev_pc   = bus.inst_pc;
         after_rst = 1'b0;
      end
   endtask

   task automatic wait_req(input string tag, input int max);
      int start = n_req;
      for (int i = 0; i < max; i++) begin
         step();
         if (n_req != start) break;
      end
      check_eq(tag, 32'(n_req != start), 32'd1);
   endtask

   task automatic wait_dlv(input string tag, input int max);
      logic [31:0] start = delivered;
      for (int i = 0; i < max; i++) begin
         step();
         if (delivered != start) break;
      end
      check_eq(tag, 32'(delivered != start), 32'd1);
   endtask

   task automatic wait_held(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         if (exp_q.size() != 0) break;
         step();
      end
      check_eq(tag, 32'(exp_q.size() != 0), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] snap_cnt;
      int snap_req;
      rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;

      // Sequential fetch at full rate: 4 instructions in 12 cycles.
      do_rst = 1'b1; step(); step(); do_rst = 1'b0;
      repeat (12) step();
      @(posedge clk); #1;
      check_eq("seq_count", fetch_count, 32'd4);
      check_eq("seq_n", 32'(dlv_pcs.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < dlv_pcs.size()) check_eq("seq_pc", dlv_pcs[i], 32'(i * 4));

      // Backpressure: decode stalls for 5 cycles while an instruction is held.
      p_inst = 0;
      wait_held("bp_held", 20);
      snap_cnt = delivered; snap_req = n_req;
      repeat (5) step();
      check_eq("bp_count", fetch_count, snap_cnt);
      check_eq("bp_no_req", 32'(n_req), 32'(snap_req));
      p_inst = 100;
      wait_dlv("bp_release", 5);

      // Redirect while waiting on a 3-cycle response.
      lat_lo = 2; lat_hi = 2;
      wait_req("wait_req_c", 20);
      force_redir = 1'b1; force_tgt = 32'h0000_0103; step();
      wait_req("redir_wait_req", 20);
      check_eq("redir_wait_addr", last_req_addr, 32'h0000_0100);
      wait_dlv("redir_wait_dlv", 20);
      check_eq("redir_wait_inst_pc", dlv_pcs[$], 32'h0000_0100);

      // Redirect in the same cycle as the response.
      lat_lo = 0; lat_hi = 0;
      wait_req("wait_req_d", 20);
      snap_cnt = delivered;
      force_redir = 1'b1; force_tgt = 32'h0000_0040; step();
      wait_req("redir_rsp_req", 20);
      check_eq("redir_rsp_addr", last_req_addr, 32'h0000_0040);
      check_eq("redir_rsp_no_old", delivered, snap_cnt);

      // Two redirects while the stale response is outstanding.
      wait_dlv("wait_dlv_e", 20);
      lat_lo = 2; lat_hi = 2;
      wait_req("wait_req_e", 20);
      force_redir = 1'b1; force_tgt = 32'h0000_0200; step();
      force_redir = 1'b1; force_tgt = 32'h0000_0300; step();
      wait_req("double_redir_req", 20);
      check_eq("double_redir_addr", last_req_addr, 32'h0000_0300);

      // Reset while holding an instruction.
      lat_lo = 0; lat_hi = 0; p_inst = 0;
      wait_held("rst_hold_held", 20);
      step();
      do_rst = 1'b1; step();
      @(posedge clk); #1;
      check_eq("rst_hold_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_eq("rst_hold_pc", pc, RST_PC);
      do_rst = 1'b0; p_inst = 100;

      // PC wrap from the top word of the address space.
      p_req = 0;
      force_redir = 1'b1; force_tgt = 32'hFFFF_FFFF; step();
      p_req = 100;
      wait_req("wrap_req0", 20);
      check_eq("wrap_addr0", last_req_addr, 32'hFFFF_FFFC);
      wait_req("wrap_req1", 20);
      check_eq("wrap_addr1", last_req_addr, 32'h0000_0000);

      // Random traffic in three flavours.
      for (int seg = 0; seg < 3; seg++) begin
         p_req   = (seg == 0) ? 100 : 60;
         p_inst  = (seg == 1) ? 100 : 50;
         p_redir = (seg == 2) ? 25 : 8;
         lat_lo  = 0;
         lat_hi  = (seg == 0) ? 1 : 4;
         for (int i = 0; i < 600; i++) begin
            do_rst = ($urandom_range(0, 199) == 0);
            step();
         end
         do_rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
